// File: rtl/acc_unit_if.sv
// acc_unit_if: control/datapath bundle between the control unit and acc_unit.
//   master : drives i_enable, i_op, i_operand; observes accumulator and status
//   slave  : the accumulator unit itself
interface acc_unit_if #(
   parameter int unsigned E_BITS = 16
);
   logic              i_enable;
   logic [2:0]        i_op;
   logic [E_BITS-1:0] i_operand;
   logic [E_BITS-1:0] o_acc;
   logic              o_zero;
   logic              o_neg;
   logic              o_carry;
   logic              o_ovf;
   logic              o_full;
   logic              o_empty;
   logic              o_err;

   modport master (
      output i_enable, i_op, i_operand,
      input  o_acc, o_zero, o_neg, o_carry, o_ovf, o_full, o_empty, o_err
   );

   modport slave (
      input  i_enable, i_op, i_operand,
      output o_acc, o_zero, o_neg, o_carry, o_ovf, o_full, o_empty, o_err
   );
endinterface

// File: rtl/acc_unit.sv
// acc_unit: accumulator with load/add/sub/and/clear, status flags and a
// LIFO shadow stack for saving/restoring the accumulator.
//   i_clock : rising-edge clock
//   i_reset : asynchronous active-low reset
//   bus     : acc_unit_if.slave (i_enable, i_op, i_operand in;
//             o_acc, o_zero, o_neg, o_carry, o_ovf, o_full, o_empty, o_err out)
module acc_unit #(
   parameter int unsigned E_BITS = 16,
   parameter int unsigned DEPTH  = 4,
   parameter bit          SAT    = 1'b0
) (
   input  logic      i_clock,
   input  logic      i_reset,
   acc_unit_if.slave bus
);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [E_BITS-1:0] MAX_POS = {1'b0, {(E_BITS-1){1'b1}}};
   localparam logic [E_BITS-1:0] MAX_NEG = {1'b1, {(E_BITS-1){1'b0}}};

   typedef enum logic [2:0] {
      OP_NOP  = 3'b000,
      OP_LOAD = 3'b001,
      OP_ADD  = 3'b010,
      OP_SUB  = 3'b011,
      OP_AND  = 3'b100,
      OP_PUSH = 3'b101,
      OP_POP  = 3'b110,
      OP_CLR  = 3'b111
   } op_e;

   logic [E_BITS-1:0] r_acc;
   logic              r_carry;
   logic              r_ovf;
   logic              r_err;
   logic              r_full;
   logic              r_empty;
   logic [CW-1:0]     r_count;
   logic [E_BITS-1:0] r_stack [DEPTH];

   op_e               w_op;
   logic [E_BITS:0]   w_sum;
   logic [E_BITS:0]   w_diff;
   logic              w_add_ovf;
   logic              w_sub_ovf;
   logic [E_BITS-1:0] w_clamp;
   logic [AW-1:0]     w_pop_idx;
   logic [E_BITS-1:0] w_acc_nxt;
   logic              w_carry_nxt;
   logic              w_ovf_nxt;
   logic              w_err_nxt;
   logic [CW-1:0]     w_cnt_nxt;
   logic              w_push;

   // Arithmetic at E_BITS+1 so the top bit is the raw carry/borrow
   assign w_op      = op_e'(bus.i_op);
   assign w_sum     = {1'b0, r_acc} + {1'b0, bus.i_operand};
   assign w_diff    = {1'b0, r_acc} - {1'b0, bus.i_operand};
   assign w_add_ovf = (r_acc[E_BITS-1] == bus.i_operand[E_BITS-1]) &&
                      (w_sum[E_BITS-1] != r_acc[E_BITS-1]);
   assign w_sub_ovf = (r_acc[E_BITS-1] != bus.i_operand[E_BITS-1]) &&
                      (w_diff[E_BITS-1] != r_acc[E_BITS-1]);
   // On overflow of either op the true result has the sign of the accumulator
   assign w_clamp   = r_acc[E_BITS-1] ? MAX_NEG : MAX_POS;
   assign w_pop_idx = AW'(r_count - CW'(1));

   // Next-state decode
   always_comb begin
      w_acc_nxt   = r_acc;
      w_carry_nxt = r_carry;
      w_ovf_nxt   = r_ovf;
      w_err_nxt   = 1'b0;
      w_cnt_nxt   = r_count;
      w_push      = 1'b0;
      if (bus.i_enable) begin
         case (w_op)
            OP_NOP:  ;
            OP_LOAD: w_acc_nxt = bus.i_operand;
            OP_ADD: begin
               w_carry_nxt = w_sum[E_BITS];
               w_ovf_nxt   = w_add_ovf;
               w_acc_nxt   = (SAT && w_add_ovf) ? w_clamp : w_sum[E_BITS-1:0];
            end
            OP_SUB: begin
               w_carry_nxt = w_diff[E_BITS];
               w_ovf_nxt   = w_sub_ovf;
               w_acc_nxt   = (SAT && w_sub_ovf) ? w_clamp : w_diff[E_BITS-1:0];
            end
            OP_AND:  w_acc_nxt = r_acc & bus.i_operand;
            OP_PUSH: begin
               if (r_full) begin
                  w_err_nxt = 1'b1;
               end else begin
                  w_push    = 1'b1;
                  w_cnt_nxt = r_count + CW'(1);
               end
            end
            OP_POP: begin
               if (r_empty) begin
                  w_err_nxt = 1'b1;
               end else begin
                  w_acc_nxt = r_stack[w_pop_idx];
                  w_cnt_nxt = r_count - CW'(1);
               end
            end
            OP_CLR: begin
               w_acc_nxt   = '0;
               w_carry_nxt = 1'b0;
               w_ovf_nxt   = 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Architectural state; full/empty are registered decodes of the next count
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_acc   <= '0;
         r_carry <= 1'b0;
         r_ovf   <= 1'b0;
         r_err   <= 1'b0;
         r_count <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         r_acc   <= w_acc_nxt;
         r_carry <= w_carry_nxt;
         r_ovf   <= w_ovf_nxt;
         r_err   <= w_err_nxt;
         r_count <= w_cnt_nxt;
         r_full  <= (w_cnt_nxt == CW'(DEPTH));
         r_empty <= (w_cnt_nxt == '0);
      end
   end

   // Stack storage needs no reset: the count alone defines valid entries
   always_ff @(posedge i_clock) begin
      if (w_push) r_stack[AW'(r_count)] <= r_acc;
   end

   assign bus.o_acc   = r_acc;
   assign bus.o_zero  = (r_acc == '0);
   assign bus.o_neg   = r_acc[E_BITS-1];
   assign bus.o_carry = r_carry;
   assign bus.o_ovf   = r_ovf;
   assign bus.o_full  = r_full;
   assign bus.o_empty = r_empty;
   assign bus.o_err   = r_err;
endmodule

// File: tb/tb_acc_unit.sv
// tb_acc_unit: directed bench for acc_unit; one wrap-around and one
// saturating instance receive identical stimulus.
module tb_acc_unit;
   localparam logic [2:0] NOP  = 3'b000;
   localparam logic [2:0] LOAD = 3'b001;
   localparam logic [2:0] ADD  = 3'b010;
   localparam logic [2:0] SUB  = 3'b011;
   localparam logic [2:0] ANDO = 3'b100;
   localparam logic [2:0] PUSH = 3'b101;
   localparam logic [2:0] POP  = 3'b110;
   localparam logic [2:0] CLR  = 3'b111;

   logic clk;
   logic rst_n;
   int   n_total;
   int   n_bad;

   acc_unit_if #(.E_BITS(16)) if_w ();
   acc_unit_if #(.E_BITS(16)) if_s ();

   acc_unit #(.E_BITS(16), .DEPTH(4), .SAT(1'b0)) u_wrap (
      .i_clock (clk),
      .i_reset (rst_n),
      .bus     (if_w)
   );

   acc_unit #(.E_BITS(16), .DEPTH(4), .SAT(1'b1)) u_sat (
      .i_clock (clk),
      .i_reset (rst_n),
      .bus     (if_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic en, input logic [2:0] op, input logic [15:0] d);
      if_w.i_enable = en; if_w.i_op = op; if_w.i_operand = d;
      if_s.i_enable = en; if_s.i_op = op; if_s.i_operand = d;
   endtask

   // Called at a negedge; returns at the following negedge with results visible
   task automatic do_op(input logic [2:0] op, input logic [15:0] d);
      drive(1'b1, op, d);
      @(negedge clk);
      drive(1'b0, NOP, 16'h0000);
   endtask

   task automatic idle();
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_total = 0;
      n_bad   = 0;
      rst_n   = 1'b0;
      drive(1'b0, NOP, 16'h0000);
      idle(); idle();
      check("rst_acc",   if_w.o_acc,   16'h0000);
      check("rst_zero",  if_w.o_zero,  1'b1);
      check("rst_neg",   if_w.o_neg,   1'b0);
      check("rst_carry", if_w.o_carry, 1'b0);
      check("rst_ovf",   if_w.o_ovf,   1'b0);
      check("rst_err",   if_w.o_err,   1'b0);
      check("rst_empty", if_w.o_empty, 1'b1);
      check("rst_full",  if_w.o_full,  1'b0);
      rst_n = 1'b1;

      // Basic arithmetic
      do_op(LOAD, 16'h0005);
      do_op(ADD,  16'h0003);
      check("add_acc",   if_w.o_acc,   16'h0008);
      check("add_carry", if_w.o_carry, 1'b0);
      check("add_ovf",   if_w.o_ovf,   1'b0);
      check("add_zero",  if_w.o_zero,  1'b0);
      do_op(SUB,  16'h0008);
      check("sub_acc",   if_w.o_acc,   16'h0000);
      check("sub_zero",  if_w.o_zero,  1'b1);
      check("sub_carry", if_w.o_carry, 1'b0);
      do_op(LOAD, 16'h00F3);
      do_op(ANDO, 16'h0F0F);
      check("and_acc",   if_w.o_acc,   16'h0003);

      // Signed overflow: wrap vs saturate
      do_op(LOAD, 16'h7FFF);
      do_op(ADD,  16'h0001);
      check("wadd_acc",   if_w.o_acc,   16'h8000);
      check("wadd_ovf",   if_w.o_ovf,   1'b1);
      check("wadd_neg",   if_w.o_neg,   1'b1);
      check("wadd_carry", if_w.o_carry, 1'b0);
      check("sadd_acc",   if_s.o_acc,   16'h7FFF);
      check("sadd_ovf",   if_s.o_ovf,   1'b1);
      do_op(LOAD, 16'hFFFF);
      do_op(ADD,  16'h0001);
      check("wcy_acc",   if_w.o_acc,   16'h0000);
      check("wcy_carry", if_w.o_carry, 1'b1);
      check("wcy_ovf",   if_w.o_ovf,   1'b0);
      check("scy_acc",   if_s.o_acc,   16'h0000);
      check("scy_carry", if_s.o_carry, 1'b1);
      do_op(LOAD, 16'h8000);
      do_op(SUB,  16'h0001);
      check("wsub_acc",   if_w.o_acc,   16'h7FFF);
      check("wsub_ovf",   if_w.o_ovf,   1'b1);
      check("ssub_acc",   if_s.o_acc,   16'h8000);
      check("ssub_ovf",   if_s.o_ovf,   1'b1);
      check("ssub_carry", if_s.o_carry, 1'b0);

      // Stack fill, overflow rejection, drain, underflow rejection
      for (int i = 1; i <= 4; i++) begin
         do_op(LOAD, 16'(i));
         do_op(PUSH, 16'h0000);
         check("push_full", if_w.o_full, (i == 4) ? 1'b1 : 1'b0);
      end
      check("push_empty", if_w.o_empty, 1'b0);
      do_op(PUSH, 16'h0000);
      check("ovr_err1", if_w.o_err, 1'b1);
      do_op(PUSH, 16'h0000);
      check("ovr_err2", if_w.o_err, 1'b1);
      check("ovr_acc",  if_w.o_acc, 16'h0004);
      idle();
      check("ovr_err_clr", if_w.o_err,  1'b0);
      check("ovr_full",    if_w.o_full, 1'b1);
      do_op(LOAD, 16'h00AA);
      for (int i = 4; i >= 1; i--) begin
         do_op(POP, 16'h0000);
         check("pop_acc",   if_w.o_acc,   16'(i));
         check("pop_empty", if_w.o_empty, (i == 1) ? 1'b1 : 1'b0);
         check("pop_err",   if_w.o_err,   1'b0);
      end
      do_op(POP, 16'h0000);
      check("udr_err", if_w.o_err, 1'b1);
      check("udr_acc", if_w.o_acc, 16'h0001);
      idle();
      check("udr_err_clr", if_w.o_err, 1'b0);

      // Back-to-back PUSH then POP
      do_op(LOAD, 16'h5A5A);
      do_op(PUSH, 16'h0000);
      do_op(LOAD, 16'h0000);
      do_op(POP,  16'h0000);
      check("b2b_acc",   if_w.o_acc,   16'h5A5A);
      check("b2b_empty", if_w.o_empty, 1'b1);

      // Enable low: every op code ignored
      do_op(LOAD, 16'h1111);
      do_op(PUSH, 16'h0000);
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 3'(i), 16'hFFFF);
         @(negedge clk);
         check("dis_acc",   if_w.o_acc,   16'h1111);
         check("dis_err",   if_w.o_err,   1'b0);
         check("dis_empty", if_w.o_empty, 1'b0);
      end
      drive(1'b0, NOP, 16'h0000);
      do_op(LOAD, 16'h0000);
      do_op(SUB,  16'h0001);
      check("bor_acc",   if_w.o_acc,   16'hFFFF);
      check("bor_carry", if_w.o_carry, 1'b1);
      check("bor_ovf",   if_w.o_ovf,   1'b0);
      do_op(CLR,  16'h0000);
      check("clr_acc",   if_w.o_acc,   16'h0000);
      check("clr_carry", if_w.o_carry, 1'b0);
      check("clr_empty", if_w.o_empty, 1'b0);
      do_op(POP,  16'h0000);
      check("clr_pop",   if_w.o_acc,   16'h1111);

      // Asynchronous reset between edges
      do_op(SUB,  16'h0001);
      do_op(PUSH, 16'h0000);
      do_op(PUSH, 16'h0000);
      do_op(LOAD, 16'h1234);
      check("pre_acc", if_w.o_acc, 16'h1234);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_acc",   if_w.o_acc,   16'h0000);
      check("arst_empty", if_w.o_empty, 1'b1);
      check("arst_zero",  if_w.o_zero,  1'b1);
      check("arst_carry", if_w.o_carry, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op(POP, 16'h0000);
      check("post_err", if_w.o_err, 1'b1);
      check("post_acc", if_w.o_acc, 16'h0000);
      do_op(LOAD, 16'h0042);
      check("post_load", if_w.o_acc, 16'h0042);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
